// File: rtl/mac_result_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_result_serializer_pkg
// Description : Shared MAC result-path constants, mode codes and the
//               serializer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_result_serializer_pkg;

    localparam int MAC_MIN_WIDTH  = 8;
    localparam int MAC_ACC_WIDTH  = 32;
    localparam int MAC_BEAT_CNT_W = 3;

    typedef enum logic [1:0] {
        MAC_SINGLE = 2'b00,
        MAC_DUAL   = 2'b01,
        MAC_QUAD   = 2'b10,
        MAC_RSVD   = 2'b11
    } mac_mode_e;

    typedef enum logic [0:0] {
        MAC_SER_IDLE = 1'b0,
        MAC_SER_SEND = 1'b1
    } mac_ser_state_e;

endpackage
`default_nettype wire

// File: rtl/mac_beat_count.sv
`default_nettype none
// ============================================================================
// Module      : mac_beat_count
// Description : Maps a MAC mode / accumulate flag to the number of
//               MIN_W-wide beats needed to carry the packed result word.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_beat_count
    import mac_result_serializer_pkg::*;
(
    input  logic [1:0]                i_mode,
    input  logic                      i_acc,
    output logic [MAC_BEAT_CNT_W-1:0] o_beats
);

    // Accumulate mode always carries the full accumulator word.
    always_comb begin
        o_beats = 3'd4;
        if (!i_acc) begin
            case (mac_mode_e'(i_mode))
                MAC_SINGLE: o_beats = 3'd2;
                MAC_DUAL:   o_beats = 3'd3;
                default:    o_beats = 3'd4;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mac_result_serializer
// Description : Captures a MAC result word and streams it LSB-first as
//               MIN_W-bit beats over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_result_serializer
    import mac_result_serializer_pkg::*;
#(
    parameter int MIN_W = MAC_MIN_WIDTH,
    parameter int ACC_W = MAC_ACC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MIN_W-1:0] out_data,
    output logic             out_last
);

    mac_ser_state_e              r_state;
    mac_ser_state_e              w_state_nxt;
    logic [ACC_W-1:0]            r_shift;
    logic [ACC_W-1:0]            w_shift_nxt;
    logic [MAC_BEAT_CNT_W-1:0]   r_beats_left;
    logic [MAC_BEAT_CNT_W-1:0]   w_beats_nxt;
    logic [MAC_BEAT_CNT_W-1:0]   w_beat_cnt;
    logic                        w_send;
    logic                        w_last;
    logic                        w_load;

    mac_beat_count u_beat_count (
        .i_mode  (in_mode),
        .i_acc   (in_acc),
        .o_beats (w_beat_cnt)
    );

    // in_ready is combinational from out_ready so the final beat and the
    // next capture share a cycle; downstream must not loop back on it.
    always_comb begin
        w_send      = (r_state == MAC_SER_SEND);
        w_last      = (r_beats_left == 3'd1);
        in_ready    = !rst && (!w_send || (w_last && out_ready));
        w_load      = in_valid && in_ready;
        out_valid   = !rst && w_send;
        out_last    = out_valid && w_last;
        out_data    = out_valid ? r_shift[MIN_W-1:0] : '0;

        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_beats_nxt = r_beats_left;

        case (r_state)
            MAC_SER_IDLE: begin
                if (w_load) begin
                    w_state_nxt = MAC_SER_SEND;
                    w_shift_nxt = in_data;
                    w_beats_nxt = w_beat_cnt;
                end
            end
            MAC_SER_SEND: begin
                if (out_ready) begin
                    if (!w_last) begin
                        w_shift_nxt = r_shift >> MIN_W;
                        w_beats_nxt = r_beats_left - 3'd1;
                    end else if (w_load) begin
                        w_shift_nxt = in_data;
                        w_beats_nxt = w_beat_cnt;
                    end else begin
                        w_state_nxt = MAC_SER_IDLE;
                        w_shift_nxt = '0;
                        w_beats_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = MAC_SER_IDLE;
                w_shift_nxt = '0;
                w_beats_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= MAC_SER_IDLE;
            r_shift      <= '0;
            r_beats_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_beats_left <= w_beats_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_result_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mac_result_serializer
// Description : Self-checking bench for mac_result_serializer against a
//               queue-based beat model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_result_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        in_acc = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;

    always #5 clk = ~clk;

    mac_result_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    typedef struct {logic [7:0] d; logic l;} beat_t;
    typedef struct {logic [31:0] d; logic [1:0] m; logic a;} word_t;

    beat_t      exp_q[$];
    word_t      pend_q[$];
    logic [7:0] seen_q[$];
    int         seen_cyc[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    function automatic int nbeats(input logic [1:0] m, input logic a);
        if (a) return 4;
        if (m == 2'b00) return 2;
        if (m == 2'b01) return 3;
        return 4;
    endfunction

    task automatic push_word(input logic [31:0] d, input logic [1:0] m, input logic a);
        int n;
        beat_t b;
        n = nbeats(m, a);
        for (int i = 0; i < n; i++) begin
            b.d = 8'((d >> (8 * i)) & 32'hFF);
            b.l = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    // One clock of stimulus with the model's per-cycle expectations.
    task automatic run_cycle(input logic r, input logic iv, input logic [31:0] d,
                             input logic [1:0] m, input logic a, input logic ordy);
        logic e_valid, e_ready;
        beat_t e_b;
        rst = r; in_valid = iv; in_data = d; in_mode = m; in_acc = a; out_ready = ordy;
        #1;
        e_valid = !r && (exp_q.size() > 0);
        e_ready = !r && ((exp_q.size() == 0) || (exp_q.size() == 1 && ordy));
        n_cmp++;
        if (out_valid !== e_valid) begin
            n_fail++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_valid);
        end
        n_cmp++;
        if (in_ready !== e_ready) begin
            n_fail++;
            $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_ready);
        end
        if (e_valid) begin
            e_b = exp_q[0];
            n_cmp++;
            if (out_data !== e_b.d) begin
                n_fail++;
                $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, e_b.d);
            end
            n_cmp++;
            if (out_last !== e_b.l) begin
                n_fail++;
                $display("FAIL out_last cyc=%0d got=%b exp=%b", cyc, out_last, e_b.l);
            end
        end else begin
            n_cmp++;
            if (out_last !== 1'b0 || (r && out_data !== 8'h00)) begin
                n_fail++;
                $display("FAIL idle_outputs cyc=%0d got last=%b data=%h exp last=0 data=00",
                         cyc, out_last, out_data);
            end
        end
        if (r) begin
            exp_q.delete();
        end else begin
            if (e_valid && ordy) begin
                seen_q.push_back(out_data);
                seen_cyc.push_back(cyc);
                void'(exp_q.pop_front());
            end
            if (iv && e_ready) push_word(d, m, a);
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic drain(input bit rnd_rdy, input bit rnd_gap, input int budget);
        int k;
        k = 0;
        while ((pend_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
            logic  iv, ordy, accept;
            word_t w;
            iv = (pend_q.size() > 0) && (!rnd_gap || $urandom_range(3) != 0);
            if (iv) w = pend_q[0];
            else begin
                w.d = $urandom;
                w.m = 2'($urandom);
                w.a = 1'($urandom);
            end
            ordy   = rnd_rdy ? ($urandom_range(2) != 0) : 1'b1;
            accept = iv && (exp_q.size() == 0 || (exp_q.size() == 1 && ordy));
            run_cycle(1'b0, iv, w.d, w.m, w.a, ordy);
            if (accept) void'(pend_q.pop_front());
            k++;
        end
        n_cmp++;
        if (pend_q.size() > 0 || exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout got pending=%0d beats_left=%0d exp 0/0",
                     pend_q.size(), exp_q.size());
            pend_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic clear_seen();
        seen_q.delete();
        seen_cyc.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, $urandom, 2'b10, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b1);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_word(input string name, input logic [31:0] d, input logic [1:0] m,
                             input logic a, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input int n);
        logic [7:0] e[4];
        word_t w;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        clear_seen();
        w.d = d; w.m = m; w.a = a;
        pend_q.push_back(w);
        drain(1'b0, 1'b0, 20);
        run_cycle(1'b0, 1'b0, $urandom, 2'b00, 1'b0, 1'b1);
        n_cmp++;
        if (seen_q.size() != n) begin
            n_fail++;
            $display("FAIL %s_count got=%0d exp=%0d", name, seen_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_cmp++;
                if (seen_q[i] !== e[i] || seen_cyc[i] != seen_cyc[0] + i) begin
                    n_fail++;
                    $display("FAIL %s_beat%0d got=%h@%0d exp=%h@%0d", name, i,
                             seen_q[i], seen_cyc[i], e[i], seen_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_seen();
        run_cycle(1'b0, 1'b1, 32'h8765_4321, 2'b10, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, $urandom, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b1, $urandom, 2'($urandom), 1'($urandom), 1'b0);
            n_cmp++;
            if (out_data !== 8'h43 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d got data=%h valid=%b exp 43/1", i, out_data, out_valid);
            end
        end
        drain(1'b0, 1'b0, 10);
        n_cmp++;
        if (seen_q.size() != 4 || seen_q[0] !== 8'h21 || seen_q[1] !== 8'h43 ||
            seen_q[2] !== 8'h65 || seen_q[3] !== 8'h87) begin
            n_fail++;
            $display("FAIL backpressure_seq got %0d beats exp 21 43 65 87", seen_q.size());
        end
    endtask

    task automatic test_back_to_back();
        word_t w;
        logic [7:0] e[4];
        e[0] = 8'h22; e[1] = 8'h11; e[2] = 8'h44; e[3] = 8'h33;
        clear_seen();
        w.m = 2'b00; w.a = 1'b0;
        w.d = 32'h0000_1122; pend_q.push_back(w);
        w.d = 32'h0000_3344; pend_q.push_back(w);
        drain(1'b0, 1'b0, 20);
        n_cmp++;
        if (seen_q.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d exp=4", seen_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (seen_q[i] !== e[i] || seen_cyc[i] != seen_cyc[0] + i) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d got=%h@%0d exp=%h@%0d", i, seen_q[i],
                             seen_cyc[i], e[i], seen_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        clear_seen();
        run_cycle(1'b0, 1'b1, 32'h8765_4321, 2'b10, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, $urandom, 2'b00, 1'b0, 1'b1);
        run_cycle(1'b1, 1'b0, $urandom, 2'b00, 1'b0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid got valid=%b in_ready=%b exp 0/0", out_valid, in_ready);
        end
        run_cycle(1'b1, 1'b0, $urandom, 2'b00, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, $urandom, 2'b00, 1'b0, 1'b1);
        n_cmp++;
        if (seen_q.size() != 1 || seen_q[0] !== 8'h21) begin
            n_fail++;
            $display("FAIL rst_mid_partial got %0d beats exp 1 (21)", seen_q.size());
        end
        test_word("post_rst", 32'hCAFE_5A6B, 2'b00, 1'b0, 8'h6B, 8'h5A, 8'h00, 8'h00, 2);
    endtask

    task automatic test_random();
        word_t w;
        for (int i = 0; i < 40; i++) begin
            w.d = $urandom;
            w.m = 2'($urandom);
            w.a = ($urandom_range(3) == 0);
            pend_q.push_back(w);
        end
        drain(1'b1, 1'b1, 2000);
    endtask

    initial begin
        test_reset();
        test_word("single", 32'hDEAD_BEEF, 2'b00, 1'b0, 8'hEF, 8'hBE, 8'h00, 8'h00, 2);
        test_word("dual",   32'h0012_3456, 2'b01, 1'b0, 8'h56, 8'h34, 8'h12, 8'h00, 3);
        test_word("quad",   32'h8765_4321, 2'b10, 1'b0, 8'h21, 8'h43, 8'h65, 8'h87, 4);
        test_word("acc",    32'h0102_0304, 2'b00, 1'b1, 8'h04, 8'h03, 8'h02, 8'h01, 4);
        test_word("rsvd",   32'hA1B2_C3D4, 2'b11, 1'b0, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 4);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
